seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 95 +++++++++
 tb/tb_seven_seg_scanner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Multiplexed four-digit seven-segment scanner: prescaled digit rotation,
// frame-synchronous (tear-free) value updates and optional leading-zero blanking.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value_in,
    output logic        busy,
    output logic [3:0]  D0,
    output logic [3:0]  D1,
    output logic [3:0]  D2,
    output logic [3:0]  D3,
    output logic [1:0]  sel,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int            CW   = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] count_reg, count_next;
    logic [1:0]    sel_reg, sel_next;
    logic [15:0]   pending_reg, pending_next;
    logic [15:0]   display_reg, display_next;
    logic          busy_reg, busy_next;

    logic          slot_tick;
    logic [1:0]    digit_idx;
    logic [3:0]    blank;

    assign slot_tick  = (count_reg == LAST);
    assign frame_tick = slot_tick && (sel_reg == 2'b11);

    always_comb begin
        count_next   = slot_tick ? '0 : count_reg + 1'b1;
        sel_next     = slot_tick ? sel_reg + 2'd1 : sel_reg;
        pending_next = pending_reg;
        display_next = display_reg;
        busy_next    = busy_reg;
        // A boundary only commits a value captured in an earlier cycle, so a
        // load coinciding with the boundary waits for the next one.
        if (frame_tick && busy_reg) begin
            display_next = pending_reg;
            busy_next    = 1'b0;
        end else if (load && !busy_reg) begin
            pending_next = value_in;
            busy_next    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            sel_reg     <= 2'b00;
            pending_reg <= 16'h0000;
            display_reg <= 16'h0000;
            busy_reg    <= 1'b0;
        end else begin
            count_reg   <= count_next;
            sel_reg     <= sel_next;
            pending_reg <= pending_next;
            display_reg <= display_next;
            busy_reg    <= busy_next;
        end
    end

    // Blanking chains downward from the leftmost digit; digit 0 always shows.
    assign blank[0] = 1'b0;
    assign blank[3] = (BLANK_EN != 1'b0) && (display_reg[15:12] == 4'd0);
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_blank
            assign blank[gi] = blank[gi+1] && (display_reg[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    // sel 01/10/11/00 addresses digit 0/1/2/3, i.e. digit = sel - 1 modulo 4.
    assign digit_idx = sel_reg - 2'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_an
            assign an[gi] = !((digit_idx == 2'(gi)) && !blank[gi]);
        end
    endgenerate

    assign sel  = sel_reg;
    assign busy = busy_reg;
    assign D0   = display_reg[3:0];
    assign D1   = display_reg[7:4];
    assign D2   = display_reg[11:8];
    assign D3   = display_reg[15:12];

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench: one blanking instance and one non-blanking instance share stimulus.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value_in = 16'h0000;

    logic        busy_b, ft_b;
    logic [3:0]  d0_b, d1_b, d2_b, d3_b, an_b;
    logic [1:0]  sel_b;

    logic        busy_n, ft_n;
    logic [3:0]  d0_n, d1_n, d2_n, d3_n, an_n;
    logic [1:0]  sel_n;

    int checks = 0;
    int errors = 0;
    int c = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in),
        .busy(busy_b), .D0(d0_b), .D1(d1_b), .D2(d2_b), .D3(d3_b),
        .sel(sel_b), .an(an_b), .frame_tick(ft_b)
    );

    seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_EN(1'b0)) u_dut_nb (
        .clk(clk), .reset(reset), .load(load), .value_in(value_in),
        .busy(busy_n), .D0(d0_n), .D1(d1_n), .D2(d2_n), .D3(d3_n),
        .sel(sel_n), .an(an_n), .frame_tick(ft_n)
    );

    typedef struct {
        logic        load;
        logic [15:0] value;
        logic [1:0]  sel;
        logic [3:0]  an_nb;
        logic [3:0]  an_bl;
        logic        ft;
        logic        busy;
        logic [15:0] disp;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c++;
    endtask

    task automatic to_phase(input int p);
        while ((c % 16) != p) tick();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        value_in = v;
        tick();
        load = 1'b0;
    endtask

    function automatic logic [15:0] disp_b();
        return {d3_b, d2_b, d1_b, d0_b};
    endfunction

    // Unblanked anode pattern for each select code.
    function automatic logic [3:0] an_of_sel(input logic [1:0] s);
        case (s)
            2'b01:   return 4'b1110;
            2'b10:   return 4'b1101;
            2'b11:   return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    initial begin
        // Rotation frames with a mid-frame load of 0x1234 at cycle 20.
        for (int i = 0; i < 32; i++) begin
            vecs[i].load  = (i == 20);
            vecs[i].value = (i == 20) ? 16'h1234 : 16'h0000;
            vecs[i].sel   = 2'((i / 4) % 4);
            vecs[i].an_nb = an_of_sel(vecs[i].sel);
            vecs[i].an_bl = (vecs[i].sel == 2'b01) ? 4'b1110 : 4'b1111;
            vecs[i].ft    = ((i % 16) == 15);
            vecs[i].busy  = (i >= 21);
            vecs[i].disp  = 16'h0000;
        end

        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy", 16'(busy_b), 16'h0);
        check("rst_sel", 16'(sel_b), 16'h0);
        check("rst_ft", 16'(ft_b), 16'h0);
        check("rst_disp", disp_b(), 16'h0000);
        check("rst_an_blank", 16'(an_b), 16'h000f);
        check("rst_an_noblank", 16'(an_n), 16'h0007);
        reset = 1'b0;
        c = 0;

        // Table-driven rotation + tear-free load
        for (int i = 0; i < 32; i++) begin
            check($sformatf("v%0d_sel", i), 16'(sel_n), 16'(vecs[i].sel));
            check($sformatf("v%0d_an_nb", i), 16'(an_n), 16'(vecs[i].an_nb));
            check($sformatf("v%0d_an_bl", i), 16'(an_b), 16'(vecs[i].an_bl));
            check($sformatf("v%0d_ft", i), 16'(ft_n), 16'(vecs[i].ft));
            check($sformatf("v%0d_busy", i), 16'(busy_b), 16'(vecs[i].busy));
            check($sformatf("v%0d_disp", i), disp_b(), vecs[i].disp);
            load = vecs[i].load;
            value_in = vecs[i].value;
            tick();
        end
        load = 1'b0;
        check("load1234_d3", 16'(d3_b), 16'h1);
        check("load1234_d2", 16'(d2_b), 16'h2);
        check("load1234_d1", 16'(d1_b), 16'h3);
        check("load1234_d0", 16'(d0_b), 16'h4);
        check("load1234_busy", 16'(busy_b), 16'h0);
        check("load1234_sel", 16'(sel_b), 16'h0);

        // Load while busy is ignored
        to_phase(2);
        do_load(16'h1111);
        check("lwb_busy1", 16'(busy_b), 16'h1);
        to_phase(5);
        do_load(16'h2222);
        check("lwb_busy2", 16'(busy_b), 16'h1);
        to_phase(15);
        check("lwb_ft", 16'(ft_b), 16'h1);
        check("lwb_disp_before", disp_b(), 16'h1234);
        tick();
        check("lwb_disp_after", disp_b(), 16'h1111);
        check("lwb_busy_clr", 16'(busy_b), 16'h0);
        to_phase(3);
        do_load(16'h2222);
        check("lwb_reload_busy", 16'(busy_b), 16'h1);
        to_phase(15);
        tick();
        check("lwb_reload_disp", disp_b(), 16'h2222);

        // Load coinciding with the frame boundary
        to_phase(15);
        check("sim_ft", 16'(ft_b), 16'h1);
        check("sim_busy_pre", 16'(busy_b), 16'h0);
        do_load(16'hABCD);
        check("sim_disp_hold", disp_b(), 16'h2222);
        check("sim_busy", 16'(busy_b), 16'h1);
        to_phase(15);
        check("sim_disp_hold2", disp_b(), 16'h2222);
        tick();
        check("sim_disp_new", disp_b(), 16'hABCD);
        check("sim_busy_clr", 16'(busy_b), 16'h0);

        // Leading-zero blanking on 0x0070
        do_load(16'h0070);
        to_phase(15);
        tick();
        check("blk_disp", disp_b(), 16'h0070);
        for (int s = 0; s < 4; s++) begin
            logic [3:0] exp_bl;
            case (s)
                1:       exp_bl = 4'b1110;
                2:       exp_bl = 4'b1101;
                default: exp_bl = 4'b1111;
            endcase
            check($sformatf("blk_sel_s%0d", s), 16'(sel_b), 16'(s));
            check($sformatf("blk_an_bl_s%0d", s), 16'(an_b), 16'(exp_bl));
            check($sformatf("blk_an_nb_s%0d", s), 16'(an_n), 16'(an_of_sel(2'(s))));
            repeat (4) tick();
        end

        // Asynchronous reset between edges while busy
        do_load(16'h5555);
        check("ar_busy_pre", 16'(busy_b), 16'h1);
        to_phase(6);
        #2;
        reset = 1'b1;
        #1;
        check("ar_busy", 16'(busy_b), 16'h0);
        check("ar_sel", 16'(sel_b), 16'h0);
        check("ar_ft", 16'(ft_b), 16'h0);
        check("ar_disp", disp_b(), 16'h0000);
        check("ar_an_bl", 16'(an_b), 16'h000f);
        check("ar_an_nb", 16'(an_n), 16'h0007);
        @(posedge clk); #1;
        reset = 1'b0;
        c = 0;
        check("ar_rel_sel", 16'(sel_b), 16'h0);
        to_phase(15);
        check("ar_rel_ft", 16'(ft_b), 16'h1);
        tick();
        check("ar_rel_disp", disp_b(), 16'h0000);
        check("ar_rel_busy", 16'(busy_b), 16'h0);
        check("ar_rel_an", 16'(an_b), 16'h000f);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
